// File: rtl/vis_frame_arbiter.sv
// Frame arbiter for an addressable LED strip. One of up to four visualization
// sources is granted for a whole strip frame; its pixels pass straight through
// to the strip driver, and each frame is followed by an idle latch gap. The
// grant is picked either manually (mode_sel) or by dwelling DWELL_FRAMES frames
// on each source in turn.
module vis_frame_arbiter #(
  parameter int N_SRC        = 4,
  parameter int PIXELS       = 40,
  parameter int DWELL_FRAMES = 256,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode_sel,
  input  logic                  auto_cycle,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [24*N_SRC-1:0]   src_data,
  output logic [N_SRC-1:0]      src_ready,
  output logic [23:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            active_src,
  output logic                  frame_done
);

  localparam int PIX_W = (PIXELS > 1)       ? $clog2(PIXELS)       : 1;
  localparam int GAP_W = (GAP_CYCLES > 1)   ? $clog2(GAP_CYCLES)   : 1;
  localparam int FRM_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(DWELL_FRAMES - 1);
  localparam logic [1:0]       SRC_LAST = 2'(N_SRC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         grant, grant_nxt;
  logic [1:0]         rr_idx, rr_nxt;
  logic [PIX_W-1:0]   pix_cnt, pix_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [FRM_W-1:0]   frm_cnt, frm_nxt;

  logic               sel_valid;
  logic [23:0]        sel_data;

  // An index that names a source this instance does not have falls back to source 0.
  function automatic logic [1:0] clamp_src(input logic [1:0] idx);
    return (int'(idx) >= N_SRC) ? 2'd0 : idx;
  endfunction

  // Round-robin successor, wrapping after the last populated source.
  function automatic logic [1:0] next_src(input logic [1:0] idx);
    return (idx == SRC_LAST) ? 2'd0 : idx + 2'd1;
  endfunction

  assign active_src = grant;

  // Pick the granted source's valid and pixel out of the flattened input buses.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant == 2'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[24*i +: 24];
      end
    end
  end

  // Next-state, counter updates and the combinational handshake outputs.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    pix_nxt    = pix_cnt;
    gap_nxt    = gap_cnt;
    frm_nxt    = frm_cnt;
    rr_nxt     = rr_idx;
    src_ready  = '0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_last     = 1'b0;
    frame_done = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = SELECT;
      end
      SELECT: begin
        grant_nxt = clamp_src(auto_cycle ? rr_idx : mode_sel);
        pix_nxt   = '0;
        state_nxt = STREAM;
      end
      STREAM: begin
        m_valid = sel_valid;
        m_data  = sel_data;
        m_last  = (pix_cnt == PIX_LAST);
        for (int i = 0; i < N_SRC; i++) begin
          src_ready[i] = (grant == 2'(i)) && m_ready;
        end
        if (sel_valid && m_ready) begin
          if (pix_cnt == PIX_LAST) begin
            frame_done = 1'b1;
            pix_nxt    = '0;
            gap_nxt    = GAP_LOAD;
            state_nxt  = GAP;
          end else begin
            pix_nxt = pix_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        // gap_cnt runs GAP_CYCLES-1 down to 0, giving GAP_CYCLES idle cycles.
        if (gap_cnt == '0) begin
          state_nxt = SELECT;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Dwell accounting only runs in auto mode; manual mode parks it at 0.
    if (!auto_cycle) begin
      frm_nxt = '0;
    end else if (frame_done) begin
      if (frm_cnt == FRM_LAST) begin
        frm_nxt = '0;
        rr_nxt  = next_src(rr_idx);
      end else begin
        frm_nxt = frm_cnt + 1'b1;
      end
    end
  end

  // State and counter registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      rr_idx  <= '0;
      pix_cnt <= '0;
      gap_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_idx  <= rr_nxt;
      pix_cnt <= pix_nxt;
      gap_cnt <= gap_nxt;
      frm_cnt <= frm_nxt;
    end
  end

endmodule

// File: tb/tb_vis_frame_arbiter.sv
// Directed bench for vis_frame_arbiter: manual frames, ready throttling,
// mid-frame mode change, reset abort, N_SRC=3 clamping and auto rotation.
module tb_vis_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_sel;
  logic        auto_cycle;
  logic [3:0]  src_valid;
  logic [95:0] src_data;
  logic        m_ready;

  logic [3:0]  src_ready;
  logic [23:0] m_data;
  logic        m_valid, m_last, frame_done;
  logic [1:0]  active_src;

  logic [2:0]  n3_src_ready;
  logic [23:0] n3_m_data;
  logic        n3_m_valid, n3_m_last, n3_frame_done;
  logic [1:0]  n3_active_src;

  logic [3:0]  a_src_ready;
  logic [23:0] a_m_data;
  logic        a_m_valid, a_m_last, a_frame_done;
  logic [1:0]  a_active_src;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vis_frame_arbiter u_dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .auto_cycle(auto_cycle),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .active_src(active_src), .frame_done(frame_done)
  );

  vis_frame_arbiter #(.N_SRC(3)) u_n3 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .auto_cycle(auto_cycle),
    .src_valid(src_valid[2:0]), .src_data(src_data[71:0]), .src_ready(n3_src_ready),
    .m_data(n3_m_data), .m_valid(n3_m_valid), .m_ready(m_ready), .m_last(n3_m_last),
    .active_src(n3_active_src), .frame_done(n3_frame_done)
  );

  vis_frame_arbiter #(.DWELL_FRAMES(2)) u_auto (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .auto_cycle(1'b1),
    .src_valid(src_valid), .src_data(src_data), .src_ready(a_src_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(m_ready), .m_last(a_m_last),
    .active_src(a_active_src), .frame_done(a_frame_done)
  );

  function automatic logic [23:0] pix(input int i);
    return {4'hA, 4'(i), 4'hB, 4'(i), 4'hC, 4'(i)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run the main instance until frame_done (or stop_at transfers), counting
  // transfers, m_last position, idle lead-in cycles and per-cycle errors.
  task automatic stream_frame(input int exp, input bit toggle, input int chg_at,
                              input logic [1:0] chg_to, input int stop_at,
                              output int xfers, output int last_cnt, output int last_idx,
                              output int done_cnt, output int lead, output int errs);
    logic [3:0] exp_rdy;
    bit seen;
    xfers = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; lead = 0; errs = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (toggle) m_ready = ~c[0];
      if (chg_at >= 0 && xfers == chg_at) mode_sel = chg_to;
      #1;
      if (m_valid) seen = 1;
      else if (!seen) lead++;
      exp_rdy = m_valid ? ((4'b0001 << exp) & {4{m_ready}}) : 4'b0000;
      if (src_ready != exp_rdy) errs++;
      if (m_valid && active_src != 2'(exp)) errs++;
      if (m_valid && m_ready) begin
        if (m_data != pix(exp)) errs++;
        if (m_last) begin
          last_cnt++;
          last_idx = xfers;
        end
        xfers++;
      end
      if (frame_done) begin
        done_cnt++;
        break;
      end
      if (stop_at >= 0 && xfers == stop_at) break;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_m_valid"},    32'(m_valid),    32'h0);
    check({tag, "_m_last"},     32'(m_last),     32'h0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    check({tag, "_src_ready"},  32'(src_ready),  32'h0);
    check({tag, "_m_data"},     32'(m_data),     32'h0);
    check({tag, "_active_src"}, 32'(active_src), 32'h0);
  endtask

  initial begin
    int xf, lc, li, dc, ld, er;
    bit found;
    logic [1:0] got_src;

    rst = 1'b1; mode_sel = 2'd2; auto_cycle = 1'b0; m_ready = 1'b1; src_valid = 4'hF;
    for (int i = 0; i < 4; i++) src_data[24*i +: 24] = pix(i);

    // Reset state with every source offering data.
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Manual source 2, full-rate frame.
    stream_frame(2, 1'b0, -1, 2'd0, -1, xf, lc, li, dc, ld, er);
    check("f1_xfers", 32'(xf), 32'd40);
    check("f1_last_cnt", 32'(lc), 32'd1);
    check("f1_last_idx", 32'(li), 32'd39);
    check("f1_done", 32'(dc), 32'd1);
    check("f1_errs", 32'(er), 32'd0);

    // Throttled frame; lead-in is 16 gap cycles plus the SELECT cycle.
    stream_frame(2, 1'b1, -1, 2'd0, -1, xf, lc, li, dc, ld, er);
    check("f2_gap_lead", 32'(ld), 32'd17);
    check("f2_xfers", 32'(xf), 32'd40);
    check("f2_last_cnt", 32'(lc), 32'd1);
    check("f2_last_idx", 32'(li), 32'd39);
    check("f2_done", 32'(dc), 32'd1);
    check("f2_errs", 32'(er), 32'd0);

    // Source 1, switching mode_sel to 3 after pixel 20; next frame is source 3.
    m_ready = 1'b1;
    mode_sel = 2'd1;
    stream_frame(1, 1'b0, 20, 2'd3, -1, xf, lc, li, dc, ld, er);
    check("f3_xfers", 32'(xf), 32'd40);
    check("f3_errs", 32'(er), 32'd0);
    stream_frame(3, 1'b0, -1, 2'd0, -1, xf, lc, li, dc, ld, er);
    check("f4_xfers", 32'(xf), 32'd40);
    check("f4_errs", 32'(er), 32'd0);
    check("f4_gap_lead", 32'(ld), 32'd17);

    // Abort at pixel 25 with reset, then a clean frame from pixel 0.
    stream_frame(3, 1'b0, -1, 2'd0, 25, xf, lc, li, dc, ld, er);
    check("f5_xfers", 32'(xf), 32'd25);
    check("f5_no_last", 32'(lc), 32'd0);
    check("f5_no_done", 32'(dc), 32'd0);
    rst = 1'b1;
    #1;
    check_zero_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stream_frame(3, 1'b0, -1, 2'd0, -1, xf, lc, li, dc, ld, er);
    check("f6_xfers", 32'(xf), 32'd40);
    check("f6_last_cnt", 32'(lc), 32'd1);
    check("f6_last_idx", 32'(li), 32'd39);
    check("f6_done", 32'(dc), 32'd1);
    check("f6_errs", 32'(er), 32'd0);

    // Three-source instance with mode_sel = 3 falls back to source 0.
    found = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (n3_m_valid) begin
        found = 1;
        break;
      end
    end
    check("n3_streaming", 32'(found), 32'd1);
    check("n3_active_src", 32'(n3_active_src), 32'd0);
    check("n3_src_ready", 32'(n3_src_ready), 32'h1);
    check("n3_m_data", 32'(n3_m_data), 32'(pix(0)));

    // Auto rotation with a two-frame dwell.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 9; f++) begin
      found = 0;
      got_src = 2'd0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        #1;
        if (a_frame_done) begin
          found = 1;
          got_src = a_active_src;
          break;
        end
      end
      check("auto_frame_seen", 32'(found), 32'd1);
      check("auto_active_src", 32'(got_src), 32'((f / 2) % 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vis_frame_arbiter.md
VIS_FRAME_ARBITER -- requirements
Module: vis_frame_arbiter

Interface
REQ-001 Parameter N_SRC, default 4, number of visualization sources (2..4).
REQ-002 Parameter PIXELS, default 40, pixels per strip frame.
REQ-003 Parameter DWELL_FRAMES, default 256, frames per source in auto-cycle mode.
REQ-004 Parameter GAP_CYCLES, default 16, idle cycles after each frame (strip latch gap).
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 mode_sel  in  2  manual source index.
REQ-008 auto_cycle  in  1  1 = rotate sources every DWELL_FRAMES frames; 0 = use mode_sel.
REQ-009 src_valid  in  N_SRC  per-source pixel valid.
REQ-010 src_data  in  24*N_SRC  per-source GRB pixel; source i occupies bits [24i+23:24i].
REQ-011 src_ready  out  N_SRC  per-source ready.
REQ-012 m_data  out  24  GRB pixel to strip driver.
REQ-013 m_valid  out  1  m_data valid.
REQ-014 m_ready  in  1  strip driver accepts pixel.
REQ-015 m_last  out  1  high with the final pixel (index PIXELS-1) of a frame.
REQ-016 active_src  out  2  currently granted source.
REQ-017 frame_done  out  1  one-cycle pulse on acceptance of the last pixel.

Function
REQ-018 The FSM SHALL have states IDLE, SELECT, STREAM and GAP.
REQ-019 IDLE: unconditional move to SELECT on the next cycle.
REQ-020 SELECT: latch grant = auto_cycle ? rr_idx : mode_sel; if the latched index >= N_SRC, use 0; clear pix_cnt; go to STREAM.
REQ-021 STREAM: src_ready[grant] = m_ready; all other src_ready bits = 0; m_valid = src_valid[grant]; m_data = source grant's pixel (combinational pass-through, zero latency).
REQ-022 A pixel is transferred only when m_valid and m_ready are both 1; pix_cnt increments by 1 per transfer.
REQ-023 m_last = 1 when in STREAM and pix_cnt == PIXELS-1.
REQ-024 On transfer with pix_cnt == PIXELS-1: pulse frame_done, clear pix_cnt, load gap_cnt = GAP_CYCLES-1, go to GAP.
REQ-025 GAP: m_valid = 0 and src_ready = 0; decrement gap_cnt; at 0 go to SELECT.
REQ-026 The grant SHALL change only in SELECT; mode_sel and auto_cycle changes mid-frame take effect at the next frame.
REQ-027 The frame counter increments on frame_done; in auto-cycle, at DWELL_FRAMES-1 it wraps to 0 and rr_idx advances (N_SRC-1 wraps to 0).
REQ-028 When auto_cycle = 0, the frame counter holds at 0 and rr_idx holds.
REQ-029 A stalled source (src_valid = 0) SHALL hold STREAM indefinitely; there is no timeout and no preemption.
REQ-030 active_src reflects the latched grant and is stable from SELECT through GAP.

Reset
REQ-031 On rst: state = IDLE; pix_cnt, gap_cnt, frame counter, rr_idx, grant = 0; m_valid, m_last, frame_done, src_ready = 0.
REQ-032 rst asserted mid-frame aborts the frame; no partial m_last or frame_done is produced; the first frame after release starts at pixel 0.

Verification
REQ-033 auto_cycle = 0, mode_sel = 2, src2 streams 40 pixels with m_ready = 1 -> 40 transfers, m_last on the 40th only, one frame_done, then 16 cycles with m_valid = 0.
REQ-034 m_ready toggles 1/0 every cycle during a frame -> pix_cnt advances only on handshakes; frame completes after exactly 40 transfers.
REQ-035 mode_sel changes 1 -> 3 at pixel 20 -> rest of the frame is from src1; the next frame is from src3.
REQ-036 auto_cycle = 1 with DWELL_FRAMES = 2 -> active_src sequence 0,0,1,1,2,2,3,3,0 over 9 frames.
REQ-037 rst pulsed at pixel 25 -> all outputs 0 during reset; the next frame delivers 40 pixels starting with index 0.
REQ-038 N_SRC = 3, mode_sel = 3 -> grant = 0; src_ready[3] never asserted.
